// File: rtl/display_mux_if.sv
// Display-side bus of the dual-digit seven-segment multiplexer: the two digit
// values and the blank request go in; the shared nibble and the anode enables
// come out.
`timescale 1ns/1ps
interface display_mux_if;
  logic [3:0] s0;
  logic [3:0] s1;
  logic       blank_all;
  logic [3:0] s;
  logic [1:0] an;

  modport master (output s0, output s1, output blank_all, input s, input an);
  modport slave  (input s0, input s1, input blank_all, output s, output an);
endinterface

// File: rtl/display_mux.sv
// Time-multiplexing driver for a dual-digit common-anode seven-segment display.
// Sequence BLANK1 -> DIG0 -> BLANK0 -> DIG1 -> BLANK1. The nibble bus is only
// reloaded on the edge that lights a digit, so the decoder settles during the
// dark gap and never changes while a digit is on.
`timescale 1ns/1ps
module display_mux #(
  parameter int ON_CYCLES    = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic         clk,
  input  logic         reset_n,
  display_mux_if.slave disp
);

  localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK1 = 2'd0,
    DIG0   = 2'd1,
    BLANK0 = 2'd2,
    DIG1   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  state_t          lit_state;
  logic [CW-1:0]   cnt;
  logic            phase_done;
  logic [3:0]      s_q;
  logic [1:0]      an_q;

  // Anode pattern for a state; only one digit can ever be driven low.
  function automatic logic [1:0] anode_for(input state_t st, input logic blank);
    logic [1:0] a;
    a = 2'b11;
    if (!blank) begin
      case (st)
        DIG0:    a = 2'b10;
        DIG1:    a = 2'b01;
        default: a = 2'b11;
      endcase
    end
    return a;
  endfunction

  // Phase end detection and the state that follows the current one.
  always_comb begin
    phase_done = 1'b0;
    state_nxt  = BLANK1;
    case (state)
      BLANK1: begin phase_done = (cnt == BLANK_LAST); state_nxt = DIG0;   end
      DIG0:   begin phase_done = (cnt == ON_LAST);    state_nxt = BLANK0; end
      BLANK0: begin phase_done = (cnt == BLANK_LAST); state_nxt = DIG1;   end
      DIG1:   begin phase_done = (cnt == ON_LAST);    state_nxt = BLANK1; end
      default: begin phase_done = 1'b1;               state_nxt = BLANK1; end
    endcase
    lit_state = phase_done ? state_nxt : state;
  end

  // Sequencer, phase counter, nibble capture on digit entry, registered anodes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BLANK1;
      cnt   <= '0;
      s_q   <= 4'h0;
      an_q  <= 2'b11;
    end else begin
      if (phase_done) begin
        cnt   <= '0;
        state <= state_nxt;
        if (state_nxt == DIG0) s_q <= disp.s0;
        if (state_nxt == DIG1) s_q <= disp.s1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      an_q <= anode_for(lit_state, disp.blank_all);
    end
  end

  assign disp.s  = s_q;
  assign disp.an = an_q;

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: three instances (ON=4/BLANK=2 directed, ON=1/BLANK=1,
// default parameters with random inputs) checked against a position-in-period
// reference model and directed expectations.
`timescale 1ns/1ps
module tb_display_mux;

  localparam int ONV [3] = '{4, 1, 24000};
  localparam int BLV [3] = '{2, 1, 240};

  logic       clk;
  logic [2:0] rstn;
  logic [3:0] s0v [3];
  logic [3:0] s1v [3];
  logic       bav [3];
  logic [1:0] an_o [3];
  logic [3:0] s_o [3];

  display_mux_if ifa ();
  display_mux_if ifb ();
  display_mux_if ifc ();

  display_mux #(.ON_CYCLES(4), .BLANK_CYCLES(2)) dut_a (.clk(clk), .reset_n(rstn[0]), .disp(ifa));
  display_mux #(.ON_CYCLES(1), .BLANK_CYCLES(1)) dut_b (.clk(clk), .reset_n(rstn[1]), .disp(ifb));
  display_mux dut_c (.clk(clk), .reset_n(rstn[2]), .disp(ifc));

  assign ifa.s0 = s0v[0]; assign ifa.s1 = s1v[0]; assign ifa.blank_all = bav[0];
  assign ifb.s0 = s0v[1]; assign ifb.s1 = s1v[1]; assign ifb.blank_all = bav[1];
  assign ifc.s0 = s0v[2]; assign ifc.s1 = s1v[2]; assign ifc.blank_all = bav[2];
  assign an_o[0] = ifa.an; assign s_o[0] = ifa.s;
  assign an_o[1] = ifb.an; assign s_o[1] = ifb.s;
  assign an_o[2] = ifc.an; assign s_o[2] = ifc.s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the 2*(ON+BLANK) period after each edge.
  int         k [3];
  logic [3:0] s_exp [3];
  logic [1:0] an_exp [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rstn[i]) begin
        k[i]      = 0;
        s_exp[i]  = 4'h0;
        an_exp[i] = 2'b11;
      end else begin
        int pos, b, o, p;
        logic [1:0] lit;
        b = BLV[i];
        o = ONV[i];
        p = 2 * (o + b);
        k[i] = k[i] + 1;
        pos = k[i] % p;
        if (pos == b) s_exp[i] = s0v[i];
        else if (pos == 2 * b + o) s_exp[i] = s1v[i];
        if (pos >= b && pos < b + o) lit = 2'b10;
        else if (pos >= 2 * b + o) lit = 2'b01;
        else lit = 2'b11;
        an_exp[i] = bav[i] ? 2'b11 : lit;
      end
    end
  end

  int         n_checks;
  int         n_err;
  int         e;
  int         ea;
  bit         rnd_c;
  bit         rnd_ba;
  logic [1:0] prev_an_c;
  logic [3:0] prev_s_c;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    e++;
    ea++;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("an_model%0d", i), 8'(an_o[i]), 8'(an_exp[i]));
      check($sformatf("s_model%0d", i), 8'(s_o[i]), 8'(s_exp[i]));
      check($sformatf("an_not_00_%0d", i), 8'(an_o[i] == 2'b00), 8'd0);
    end
    if (rstn[1]) begin
      check("b_cnt_zero", 8'(dut_b.cnt), 8'd0);
      case (e % 4)
        1:       check("b_seq", 8'(an_o[1]), 8'h2);
        3:       check("b_seq", 8'(an_o[1]), 8'h1);
        default: check("b_seq", 8'(an_o[1]), 8'h3);
      endcase
    end
    if (an_o[2] != 2'b11 && prev_an_c != 2'b11)
      check("c_s_hold", 8'(s_o[2]), 8'(prev_s_c));
    prev_an_c = an_o[2];
    prev_s_c  = s_o[2];
    if (rnd_c) begin
      s0v[2] = 4'($urandom_range(0, 15));
      s1v[2] = 4'($urandom_range(0, 15));
      bav[2] = rnd_ba ? ($urandom_range(0, 7) == 0) : 1'b0;
    end
  endtask

  initial begin
    int guard;
    int lit_len;
    n_checks = 0; n_err = 0; e = 0; ea = 0;
    rnd_c = 1'b1; rnd_ba = 1'b1;
    prev_an_c = 2'b11; prev_s_c = 4'h0;
    rstn = 3'b000;
    s0v[0] = 4'h3; s1v[0] = 4'hA; bav[0] = 1'b0;
    s0v[1] = 4'h5; s1v[1] = 4'hC; bav[1] = 1'b0;
    s0v[2] = 4'h1; s1v[2] = 4'h2; bav[2] = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_an_a", 8'(an_o[0]), 8'h3);
    check("rst_s_a", 8'(s_o[0]), 8'h0);
    check("rst_an_c", 8'(an_o[2]), 8'h3);
    @(negedge clk);
    rstn = 3'b111;
    e = 0; ea = 0;

    // Tests 1-3 on instance A
    for (int n = 0; n < 51; n++) begin
      step();
      case (e)
        1:  check("t1_e1_an", 8'(an_o[0]), 8'h3);
        2:  begin check("t1_e2_an", 8'(an_o[0]), 8'h2); check("t1_e2_s", 8'(s_o[0]), 8'h3); end
        5:  begin check("t1_e5_an", 8'(an_o[0]), 8'h2); check("t1_e5_s", 8'(s_o[0]), 8'h3); end
        6:  begin check("t1_e6_an", 8'(an_o[0]), 8'h3); check("t1_e6_s", 8'(s_o[0]), 8'h3); end
        8:  begin check("t1_e8_an", 8'(an_o[0]), 8'h1); check("t1_e8_s", 8'(s_o[0]), 8'hA); end
        11: check("t1_e11_an", 8'(an_o[0]), 8'h1);
        12: check("t1_e12_an", 8'(an_o[0]), 8'h3);
        14: begin check("t1_e14_an", 8'(an_o[0]), 8'h2); check("t1_e14_s", 8'(s_o[0]), 8'h3); end
        15: s0v[0] = 4'h7;
        17: check("t2_e17_s", 8'(s_o[0]), 8'h3);
        20: begin check("t2_e20_an", 8'(an_o[0]), 8'h1); check("t2_e20_s", 8'(s_o[0]), 8'hA); end
        26: begin check("t2_e26_an", 8'(an_o[0]), 8'h2); check("t2_e26_s", 8'(s_o[0]), 8'h7); end
        32: begin check("t3_e32_an", 8'(an_o[0]), 8'h1); bav[0] = 1'b1; end
        33: check("t3_e33_an", 8'(an_o[0]), 8'h3);
        35: begin check("t3_e35_an", 8'(an_o[0]), 8'h3); bav[0] = 1'b0; end
        36: check("t3_e36_an", 8'(an_o[0]), 8'h3);
        38: check("t3_e38_an", 8'(an_o[0]), 8'h2);
        44: begin check("t3_e44_an", 8'(an_o[0]), 8'h1); bav[0] = 1'b1; end
        45: begin check("t3_e45_an", 8'(an_o[0]), 8'h3); bav[0] = 1'b0; end
        46: check("t3_e46_an", 8'(an_o[0]), 8'h1);
        48: check("t3_e48_an", 8'(an_o[0]), 8'h3);
        50: check("t3_e50_an", 8'(an_o[0]), 8'h2);
        default: ;
      endcase
    end

    // Test 4: asynchronous reset between edges in the middle of DIG0
    check("t4_pre_an", 8'(an_o[0]), 8'h2);
    #2;
    rstn[0] = 1'b0;
    #1;
    check("t4_async_an", 8'(an_o[0]), 8'h3);
    check("t4_async_s", 8'(s_o[0]), 8'h0);
    step();
    step();
    rstn[0] = 1'b1;
    ea = 0;
    for (int n = 0; n < 14; n++) begin
      step();
      case (ea)
        1:  check("t4_e1_an", 8'(an_o[0]), 8'h3);
        2:  begin check("t4_e2_an", 8'(an_o[0]), 8'h2); check("t4_e2_s", 8'(s_o[0]), 8'h7); end
        6:  check("t4_e6_an", 8'(an_o[0]), 8'h3);
        8:  begin check("t4_e8_an", 8'(an_o[0]), 8'h1); check("t4_e8_s", 8'(s_o[0]), 8'hA); end
        12: check("t4_e12_an", 8'(an_o[0]), 8'h3);
        14: check("t4_e14_an", 8'(an_o[0]), 8'h2);
        default: ;
      endcase
    end

    // Test 6: random inputs on the default-parameter instance
    while (e < 10000) step();
    rnd_ba = 1'b0;
    bav[2] = 1'b0;
    step();
    guard = 0;
    while (an_o[2] != 2'b11 && guard < 30000) begin guard++; step(); end
    check("t6_wait_dark", 8'(an_o[2]), 8'h3);
    guard = 0;
    while (an_o[2] == 2'b11 && guard < 30000) begin guard++; step(); end
    check("t6_wait_lit", 8'(an_o[2] != 2'b11), 8'd1);
    lit_len = 0;
    while (an_o[2] != 2'b11 && lit_len < 30000) begin lit_len++; step(); end
    n_checks++;
    assert (lit_len == 24000) else begin
      n_err++;
      $error("FAIL t6_lit_len observed=%0d expected=%0d", lit_len, 24000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
